// File: rtl/assoc_cache.sv
// assoc_cache: set-associative cache tag/data store with a two-stage
// lookup pipeline.
//
// The accept cycle reads every way's tag and data RAM at i_req_index and
// registers the request. The response cycle compares tags, reports the hit
// way (or, for a fill, the victim way) together with that way's state from
// before the operation, and commits any update on the closing clock edge.
//
// Ports
//   clk, n_rst        clock, asynchronous active-low reset
//   i_req_valid       request present
//   o_req_ready       request taken when valid && ready; low for one cycle
//                     while a write, fill or invalidate commits
//   i_req_op          00 read, 01 write, 10 fill, 11 invalidate
//   i_req_offset      byte offset in line (word aligned, low bits ignored)
//   i_req_index       set index
//   i_req_tag         lookup / fill tag
//   i_req_byte_en     write byte enables
//   i_req_wdata       write word
//   i_req_fdata       fill line
//   o_rsp_valid       response strobe; all other o_rsp_* are 0 when low
//   o_rsp_hit         valid way with matching tag
//   o_rsp_way         hit way, or victim way for a fill
//   o_rsp_valid_line  reported way's valid bit before the operation
//   o_rsp_dirty       reported way's dirty bit before the operation
//   o_rsp_tag         reported way's old tag
//   o_rsp_line        reported way's old line (writeback data)
//   o_rsp_rdata       hit-way word at the offset, 0 on miss

module assoc_cache_dp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 32,
    parameter int NUM_WAYS   = 2,
    localparam int WB   = DATA_WIDTH / 8,
    localparam int SETS = CACHE_SIZE / (LINE_SIZE * NUM_WAYS),
    localparam int OW   = $clog2(LINE_SIZE),
    localparam int IW   = $clog2(SETS),
    localparam int TW   = ADDR_WIDTH - IW - OW,
    localparam int LW   = LINE_SIZE * 8,
    localparam int WW   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [OW-1:0]         i_req_offset,
    input  logic [IW-1:0]         i_req_index,
    input  logic [TW-1:0]         i_req_tag,
    input  logic [WB-1:0]         i_req_byte_en,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [LW-1:0]         i_req_fdata,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_hit,
    output logic [WW-1:0]         o_rsp_way,
    output logic                  o_rsp_valid_line,
    output logic                  o_rsp_dirty,
    output logic [TW-1:0]         o_rsp_tag,
    output logic [LW-1:0]         o_rsp_line,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata
);
    localparam int BW = $clog2(WB);

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    if (!is_pow2(DATA_WIDTH) || DATA_WIDTH < 8 || !is_pow2(CACHE_SIZE) ||
        !is_pow2(LINE_SIZE) || !is_pow2(NUM_WAYS) || LINE_SIZE < WB ||
        SETS < 2 || TW < 1) begin : g_bad_params
        $error("assoc_cache: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_INVAL = 2'b11
    } op_e;

    // response-stage request registers
    logic                  s1_valid;
    op_e                   s1_op;
    logic [OW-1:0]         s1_offset;
    logic [IW-1:0]         s1_index;
    logic [TW-1:0]         s1_tag;
    logic [WB-1:0]         s1_byte_en;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic [LW-1:0]         s1_fdata;

    // per-set state in flops
    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [NUM_WAYS-1:0] dirty_q [SETS];
    logic [WW-1:0]       ptr_q   [SETS];

    logic [TW-1:0] tag_rd  [NUM_WAYS];
    logic [LW-1:0] data_rd [NUM_WAYS];

    logic                accept;
    logic [NUM_WAYS-1:0] set_valid;
    logic [NUM_WAYS-1:0] set_dirty;
    logic                hit;
    logic [WW-1:0]       hit_way;
    logic [WW-1:0]       vic_way;
    logic                vic_from_ptr;
    logic [WW-1:0]       rep_way;
    logic [LW-1:0]       rep_line;
    logic [OW-1:0]       word_off;
    int                  word_bit;
    logic [DATA_WIDTH-1:0] rep_word;
    logic [LW-1:0]       wr_line;
    logic [LW-1:0]       line_wdata;
    logic                do_write;
    logic                do_fill;
    logic                do_inval;
    logic [NUM_WAYS-1:0] data_we;
    logic [NUM_WAYS-1:0] tag_we;

    // Any update commits at the end of its response cycle; holding ready low
    // there keeps the next request's RAM read from racing the write.
    assign o_req_ready = !(s1_valid && (s1_op != OP_READ));
    assign accept      = i_req_valid && o_req_ready;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assoc_cache_dp_ram #(.WIDTH(TW), .DEPTH(SETS)) u_tag_ram (
            .clk   (clk),
            .we    (tag_we[w]),
            .waddr (s1_index),
            .wdata (s1_tag),
            .re    (accept),
            .raddr (i_req_index),
            .rdata (tag_rd[w])
        );
        assoc_cache_dp_ram #(.WIDTH(LW), .DEPTH(SETS)) u_data_ram (
            .clk   (clk),
            .we    (data_we[w]),
            .waddr (s1_index),
            .wdata (line_wdata),
            .re    (accept),
            .raddr (i_req_index),
            .rdata (data_rd[w])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) s1_valid <= 1'b0;
        else        s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op      <= op_e'(i_req_op);
            s1_offset  <= i_req_offset;
            s1_index   <= i_req_index;
            s1_tag     <= i_req_tag;
            s1_byte_en <= i_req_byte_en;
            s1_wdata   <= i_req_wdata;
            s1_fdata   <= i_req_fdata;
        end
    end

    assign set_valid = valid_q[s1_index];
    assign set_dirty = dirty_q[s1_index];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (set_valid[w] && (tag_rd[w] == s1_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Downward scan so the lowest-index invalid way wins; fall back to the
    // set's round-robin pointer only when every way is valid.
    always_comb begin
        vic_way      = ptr_q[s1_index];
        vic_from_ptr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                vic_way      = WW'(w);
                vic_from_ptr = 1'b0;
            end
        end
    end

    assign rep_way  = (s1_op == OP_FILL) ? vic_way : hit_way;
    assign rep_line = data_rd[rep_way];
    assign word_off = (s1_offset >> BW) << BW;
    assign word_bit = int'(word_off) * 8;
    assign rep_word = rep_line[word_bit +: DATA_WIDTH];

    always_comb begin
        wr_line = rep_line;
        for (int b = 0; b < WB; b++) begin
            if (s1_byte_en[b]) wr_line[word_bit + 8*b +: 8] = s1_wdata[8*b +: 8];
        end
    end

    assign do_write   = s1_valid && (s1_op == OP_WRITE) && hit;
    assign do_fill    = s1_valid && (s1_op == OP_FILL);
    assign do_inval   = s1_valid && (s1_op == OP_INVAL) && hit;
    assign line_wdata = do_fill ? s1_fdata : wr_line;

    always_comb begin
        data_we = '0;
        tag_we  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if ((do_write && hit_way == WW'(w)) || (do_fill && vic_way == WW'(w)))
                data_we[w] = 1'b1;
            if (do_fill && vic_way == WW'(w))
                tag_we[w] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (do_write) dirty_q[s1_index][hit_way] <= 1'b1;
            if (do_fill) begin
                valid_q[s1_index][vic_way] <= 1'b1;
                dirty_q[s1_index][vic_way] <= 1'b0;
                if (vic_from_ptr)
                    ptr_q[s1_index] <= (vic_way == WW'(NUM_WAYS - 1)) ? '0 : vic_way + 1'b1;
            end
            if (do_inval) begin
                valid_q[s1_index][hit_way] <= 1'b0;
                dirty_q[s1_index][hit_way] <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rsp_valid      = 1'b0;
        o_rsp_hit        = 1'b0;
        o_rsp_way        = '0;
        o_rsp_valid_line = 1'b0;
        o_rsp_dirty      = 1'b0;
        o_rsp_tag        = '0;
        o_rsp_line       = '0;
        o_rsp_rdata      = '0;
        if (s1_valid) begin
            o_rsp_valid = 1'b1;
            if ((s1_op == OP_FILL) || hit) begin
                o_rsp_way        = rep_way;
                o_rsp_valid_line = set_valid[rep_way];
                o_rsp_dirty      = set_dirty[rep_way];
                o_rsp_tag        = tag_rd[rep_way];
                o_rsp_line       = rep_line;
            end
            if ((s1_op != OP_FILL) && hit) begin
                o_rsp_hit   = 1'b1;
                o_rsp_rdata = rep_word;
            end
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;
    localparam int DW = 32, NW = 2, SETS = 16, OW = 5, IW = 4, TW = 23;
    localparam int LW = 256, WB = 4, WW = 1;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, IV = 2'b11;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = '0;
    logic [OW-1:0] i_req_offset = '0;
    logic [IW-1:0] i_req_index = '0;
    logic [TW-1:0] i_req_tag = '0;
    logic [WB-1:0] i_req_byte_en = '0;
    logic [DW-1:0] i_req_wdata = '0;
    logic [LW-1:0] i_req_fdata = '0;
    logic          o_rsp_valid, o_rsp_hit, o_rsp_valid_line, o_rsp_dirty;
    logic [WW-1:0] o_rsp_way;
    logic [TW-1:0] o_rsp_tag;
    logic [LW-1:0] o_rsp_line;
    logic [DW-1:0] o_rsp_rdata;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .n_rst(n_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_offset(i_req_offset),
        .i_req_index(i_req_index), .i_req_tag(i_req_tag),
        .i_req_byte_en(i_req_byte_en), .i_req_wdata(i_req_wdata),
        .i_req_fdata(i_req_fdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_hit(o_rsp_hit), .o_rsp_way(o_rsp_way),
        .o_rsp_valid_line(o_rsp_valid_line), .o_rsp_dirty(o_rsp_dirty),
        .o_rsp_tag(o_rsp_tag), .o_rsp_line(o_rsp_line), .o_rsp_rdata(o_rsp_rdata)
    );

    typedef struct {
        logic [1:0]    op;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [OW-1:0] off;
        logic [WB-1:0] be;
        logic [DW-1:0] wdata;
        logic [LW-1:0] fdata;
    } req_t;

    typedef struct {
        logic          valid, ready, hit, vl, dirty, known;
        logic [WW-1:0] way;
        logic [TW-1:0] tag;
        logic [LW-1:0] line;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct {
        logic [1:0]    op;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [OW-1:0] off;
        logic [WB-1:0] be;
        logic [DW-1:0] wdata;
        logic [7:0]    fbase;
        logic          hit;
        logic [WW-1:0] way;
        logic          vl, dirty;
        logic [DW-1:0] rdata;
        logic          tchk;
        logic [TW-1:0] etag;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // reference model: what the cache holds, set by set
    logic          m_valid [SETS][NW];
    logic          m_dirty [SETS][NW];
    logic          m_known [SETS][NW];
    logic [TW-1:0] m_tag   [SETS][NW];
    logic [LW-1:0] m_line  [SETS][NW];
    int            m_ptr   [SETS];

    function automatic logic [LW-1:0] pat(input logic [7:0] base);
        logic [LW-1:0] p;
        for (int i = 0; i < LW/8; i++) p[8*i +: 8] = base + 8'(i);
        return p;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input int idx, input int tag,
                                input int off, input logic [3:0] be, input logic [31:0] wd,
                                input logic [7:0] fb, input logic hit, input int way,
                                input logic vl, input logic dirty, input logic [31:0] rdata,
                                input logic tchk, input int etag);
        vec_t v;
        v.op = op; v.idx = IW'(idx); v.tag = TW'(tag); v.off = OW'(off); v.be = be;
        v.wdata = wd; v.fbase = fb; v.hit = hit; v.way = WW'(way); v.vl = vl;
        v.dirty = dirty; v.rdata = rdata; v.tchk = tchk; v.etag = TW'(etag);
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model(input req_t r, output rsp_t e);
        int s, hw, v, wi;
        s = int'(r.idx);
        hw = -1;
        wi = int'(r.off) / WB;
        e = '{default: '0};
        e.valid = 1'b1;
        e.ready = (r.op == RD);
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == r.tag) hw = w;
        if (r.op == FL) begin
            v = -1;
            for (int w = 0; w < NW; w++) if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % NW;
            end
            e.way = WW'(v); e.vl = m_valid[s][v]; e.dirty = m_dirty[s][v];
            e.tag = m_tag[s][v]; e.line = m_line[s][v]; e.known = m_known[s][v];
            m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_known[s][v] = 1'b1;
            m_tag[s][v] = r.tag; m_line[s][v] = r.fdata;
        end else if (hw >= 0) begin
            e.hit = 1'b1; e.way = WW'(hw); e.vl = 1'b1; e.dirty = m_dirty[s][hw];
            e.tag = m_tag[s][hw]; e.line = m_line[s][hw]; e.known = 1'b1;
            e.rdata = m_line[s][hw][wi*DW +: DW];
            if (r.op == WR) begin
                for (int b = 0; b < WB; b++)
                    if (r.be[b]) m_line[s][hw][(wi*WB + b)*8 +: 8] = r.wdata[8*b +: 8];
                m_dirty[s][hw] = 1'b1;
            end else if (r.op == IV) begin
                m_valid[s][hw] = 1'b0;
                m_dirty[s][hw] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input req_t r);
        i_req_op = r.op; i_req_index = r.idx; i_req_tag = r.tag; i_req_offset = r.off;
        i_req_byte_en = r.be; i_req_wdata = r.wdata; i_req_fdata = r.fdata;
        i_req_valid = 1'b1;
    endtask

    task automatic grab(output rsp_t g);
        g.valid = o_rsp_valid; g.ready = o_req_ready; g.hit = o_rsp_hit;
        g.way = o_rsp_way; g.vl = o_rsp_valid_line; g.dirty = o_rsp_dirty;
        g.tag = o_rsp_tag; g.line = o_rsp_line; g.rdata = o_rsp_rdata; g.known = 1'b0;
    endtask

    task automatic send(input string nm, input req_t r, output rsp_t g);
        int n;
        @(negedge clk);
        drive(r);
        n = 0;
        while (!o_req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            n_vec++; n_err++;
            $display("FAIL %s.ready_timeout: got 0 expected 1", nm);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        grab(g);
    endtask

    task automatic cmp(input string nm, input rsp_t g, input rsp_t e);
        chk($sformatf("%s.valid", nm), LW'(g.valid), LW'(e.valid));
        chk($sformatf("%s.ready", nm), LW'(g.ready), LW'(e.ready));
        chk($sformatf("%s.hit", nm),   LW'(g.hit),   LW'(e.hit));
        chk($sformatf("%s.way", nm),   LW'(g.way),   LW'(e.way));
        chk($sformatf("%s.vline", nm), LW'(g.vl),    LW'(e.vl));
        chk($sformatf("%s.dirty", nm), LW'(g.dirty), LW'(e.dirty));
        chk($sformatf("%s.rdata", nm), LW'(g.rdata), LW'(e.rdata));
        if (e.known) begin
            chk($sformatf("%s.tag", nm),  LW'(g.tag), LW'(e.tag));
            chk($sformatf("%s.line", nm), g.line, e.line);
        end
    endtask

    vec_t tbl [20];
    req_t r;
    rsp_t g, e;

    initial begin
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NW; w++) begin
                m_known[s][w] = 1'b0; m_tag[s][w] = '0; m_line[s][w] = '0;
            end
        model_reset();

        //         op  idx tag off be     wdata         fb     hit way vl d  rdata         tchk etag
        tbl[0]  = mk(RD, 3, 5, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[1]  = mk(FL, 3, 5, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[2]  = mk(RD, 3, 5, 8, 4'h0, 32'h0,        8'h00, 1, 0, 1, 0, 32'h0B0A0908, 1, 5);
        tbl[3]  = mk(WR, 3, 5, 8, 4'h3, 32'hDEADBEEF, 8'h00, 1, 0, 1, 0, 32'h0B0A0908, 1, 5);
        tbl[4]  = mk(RD, 3, 5, 8, 4'h0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h0B0ABEEF, 1, 5);
        tbl[5]  = mk(RD, 3, 5, 11, 4'h0, 32'h0,       8'h00, 1, 0, 1, 1, 32'h0B0ABEEF, 0, 0);
        tbl[6]  = mk(IV, 3, 5, 0, 4'h0, 32'h0,        8'h00, 1, 0, 1, 1, 32'h03020100, 1, 5);
        tbl[7]  = mk(RD, 3, 5, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[8]  = mk(FL, 3, 5, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[9]  = mk(WR, 3, 5, 0, 4'hF, 32'h11223344, 8'h00, 1, 0, 1, 0, 32'h03020100, 0, 0);
        tbl[10] = mk(FL, 3, 6, 0, 4'h0, 32'h0,        8'h40, 0, 1, 0, 0, 32'h0,        0, 0);
        tbl[11] = mk(FL, 3, 7, 0, 4'h0, 32'h0,        8'h80, 0, 0, 1, 1, 32'h0,        1, 5);
        tbl[12] = mk(FL, 3, 8, 0, 4'h0, 32'h0,        8'hC0, 0, 1, 1, 0, 32'h0,        1, 6);
        tbl[13] = mk(RD, 3, 7, 0, 4'h0, 32'h0,        8'h00, 1, 0, 1, 0, 32'h83828180, 1, 7);
        tbl[14] = mk(RD, 3, 5, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[15] = mk(IV, 3, 8, 4, 4'h0, 32'h0,        8'h00, 1, 1, 1, 0, 32'hC7C6C5C4, 1, 8);
        tbl[16] = mk(IV, 3, 8, 4, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[17] = mk(RD, 4, 7, 0, 4'h0, 32'h0,        8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[18] = mk(WR, 3, 6, 0, 4'hF, 32'hCAFEF00D, 8'h00, 0, 0, 0, 0, 32'h0,        0, 0);
        tbl[19] = mk(RD, 3, 7, 28, 4'h0, 32'h0,       8'h00, 1, 0, 1, 0, 32'h9F9E9D9C, 0, 0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.rsp_valid", LW'(o_rsp_valid), LW'(0));
        chk("rst.rsp_fields", LW'(|{o_rsp_hit, o_rsp_way, o_rsp_valid_line, o_rsp_dirty,
                                    o_rsp_tag, o_rsp_line, o_rsp_rdata}), LW'(0));
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst.ready", LW'(o_req_ready), LW'(1));

        // directed table
        for (int i = 0; i < 20; i++) begin
            r.op = tbl[i].op; r.idx = tbl[i].idx; r.tag = tbl[i].tag; r.off = tbl[i].off;
            r.be = tbl[i].be; r.wdata = tbl[i].wdata; r.fdata = pat(tbl[i].fbase);
            model(r, e);
            send($sformatf("t%0d", i), r, g);
            chk($sformatf("t%0d.valid", i), LW'(g.valid), LW'(1));
            chk($sformatf("t%0d.ready", i), LW'(g.ready), LW'(tbl[i].op == RD));
            chk($sformatf("t%0d.hit", i),   LW'(g.hit),   LW'(tbl[i].hit));
            chk($sformatf("t%0d.way", i),   LW'(g.way),   LW'(tbl[i].way));
            chk($sformatf("t%0d.vline", i), LW'(g.vl),    LW'(tbl[i].vl));
            chk($sformatf("t%0d.dirty", i), LW'(g.dirty), LW'(tbl[i].dirty));
            chk($sformatf("t%0d.rdata", i), LW'(g.rdata), LW'(tbl[i].rdata));
            if (tbl[i].tchk) chk($sformatf("t%0d.tag", i), LW'(g.tag), LW'(tbl[i].etag));
        end

        // back-to-back reads: ready stays high, one in-order response per cycle
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            r = '{op: RD, idx: (k % 3 == 2) ? IW'(5) : IW'(3), tag: (k % 2 == 0) ? TW'(7) : TW'(8),
                  off: OW'(4 * k), be: '0, wdata: '0, fdata: '0};
            drive(r);
            chk($sformatf("b2b%0d.ready_in", k), LW'(o_req_ready), LW'(1));
            model(r, e);
            @(posedge clk);
            #1;
            grab(g);
            cmp($sformatf("b2b%0d", k), g, e);
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.rsp_valid", LW'(o_rsp_valid), LW'(0));
        chk("idle.rsp_fields", LW'(|{o_rsp_hit, o_rsp_way, o_rsp_valid_line, o_rsp_dirty,
                                     o_rsp_tag, o_rsp_line, o_rsp_rdata}), LW'(0));

        // reset in the response cycle of a write: the write must not land
        r = '{op: WR, idx: IW'(3), tag: TW'(7), off: OW'(0), be: 4'hF,
              wdata: 32'hFFFFFFFF, fdata: '0};
        @(negedge clk);
        drive(r);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        chk("rstwr.in_rsp", LW'(o_rsp_valid), LW'(1));
        n_rst = 1'b0;
        #1;
        chk("rstwr.rsp_dropped", LW'(o_rsp_valid), LW'(0));
        model_reset();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        r = '{op: RD, idx: IW'(3), tag: TW'(7), off: OW'(0), be: '0, wdata: '0, fdata: '0};
        model(r, e);
        send("rstwr.read", r, g);
        cmp("rstwr.read", g, e);
        r = '{op: FL, idx: IW'(3), tag: TW'(9), off: OW'(0), be: '0, wdata: '0, fdata: pat(8'hE0)};
        model(r, e);
        send("rstwr.fill", r, g);
        cmp("rstwr.fill", g, e);

        // randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            r.op = 2'($urandom_range(0, 3));
            r.idx = (k % 7 == 0) ? IW'($urandom_range(0, SETS - 1)) : IW'($urandom_range(0, 3));
            r.tag = TW'($urandom_range(0, 5));
            r.off = OW'($urandom_range(0, 31));
            r.be = WB'($urandom_range(0, 15));
            r.wdata = $urandom;
            for (int j = 0; j < LW/32; j++) r.fdata[32*j +: 32] = $urandom;
            if (r.op == FL)
                for (int w = 0; w < NW; w++)
                    if (m_valid[r.idx][w] && m_tag[r.idx][w] == r.tag) r.op = IV;
            model(r, e);
            send($sformatf("rnd%0d", k), r, g);
            cmp($sformatf("rnd%0d", k), g, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 The block SHALL have parameter CACHE_SIZE, default 1024, total data capacity in bytes.
REQ-004 The block SHALL have parameter LINE_SIZE, default 32, line size in bytes.
REQ-005 The block SHALL have parameter NUM_WAYS, default 2, associativity.
REQ-006 The block SHALL use these derived widths: WB=DATA_WIDTH/8; SETS=CACHE_SIZE/(LINE_SIZE*NUM_WAYS); OW=clog2(LINE_SIZE); IW=clog2(SETS); TW=ADDR_WIDTH-IW-OW; LW=LINE_SIZE*8; WW=max(1,clog2(NUM_WAYS)).
REQ-007 The block SHALL have these ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_op  in  2  operation: 00 read, 01 write, 10 fill, 11 invalidate
- i_req_offset  in  OW  byte offset
- i_req_index  in  IW  set index
- i_req_tag  in  TW  lookup/fill tag
- i_req_byte_en  in  WB  write byte enables
- i_req_wdata  in  DATA_WIDTH  write word
- i_req_fdata  in  LW  fill line
- o_rsp_valid  out  1  response strobe
- o_rsp_hit  out  1  tag match on a valid way
- o_rsp_way  out  WW  hit way, or victim way for fill
- o_rsp_valid_line / o_rsp_dirty  out  1 each  state of the reported way before the operation
- o_rsp_tag  out  TW  old tag of the reported way
- o_rsp_line  out  LW  old line data of the reported way (writeback data)
- o_rsp_rdata  out  DATA_WIDTH  read word

Function
REQ-008 Storage SHALL be per way: one tag dp_ram and one data dp_ram (registered read, one read and one write port); valid/dirty bits and per-set victim pointers in flops.
REQ-009 Two stages: accept cycle T reads all ways' tag/data RAMs at i_req_index and registers the request; response cycle T+1 compares tags, drives o_rsp_* with o_rsp_valid=1, and commits any write at the T+1 clock edge.
REQ-010 o_req_ready SHALL be 0 in the response cycle of an accepted write, fill or invalidate (one-cycle bubble), and 1 otherwise; back-to-back reads SHALL be accepted every cycle.
REQ-011 Hit: exactly one way with valid=1 and stored tag == request tag; o_rsp_way = that way. Multiple matches SHALL NOT occur; fill MUST NOT create a duplicate tag in a set.
REQ-012 Offset low clog2(WB) bits SHALL be ignored (word aligned); o_rsp_rdata = hit-way word at the offset; 0 on miss.
REQ-013 Read: no state change.
REQ-014 Write hit: bytes with byte_en=1 replaced, others kept; dirty set to 1. Write miss: no state change (no write-allocate).
REQ-015 Fill victim: lowest-index invalid way if any, else the set's pointer; o_rsp_way/tag/line/valid_line/dirty report the victim before overwrite; victim gets fdata, request tag, valid=1, dirty=0; o_rsp_hit=0.
REQ-016 Victim pointer SHALL advance (pointer+1) mod NUM_WAYS only when a fill used it; pointer width WW; NUM_WAYS=1 keeps it at 0.
REQ-017 Invalidate hit: report the way's old state/line, clear valid and dirty. Invalidate miss: o_rsp_hit=0, no state change.
REQ-018 When o_rsp_valid=0, all other o_rsp_* SHALL be 0.
REQ-019 Parameters SHALL be powers of two with LINE_SIZE>=WB and SETS>=2; otherwise elaboration SHALL fail.

Reset
REQ-020 On n_rst low, asynchronously: all valid, dirty and pointer bits 0; o_rsp_valid and all o_rsp_* 0; o_req_ready 1 after release.
REQ-021 Reset during a response cycle SHALL drop the response and abort the pending write; RAM contents need not clear (all lines invalid).

Verification
REQ-022 Defaults (16 sets, 2 ways, TW=23): after reset, read idx 3 tag 0x5 -> next cycle o_rsp_valid=1, hit=0, rdata=0.
REQ-023 Fill idx 3 tag 0x5 data=byte i at byte i -> way 0 victim, valid_line=0; then read offset 8 -> hit=1, way=0, rdata=0x0B0A0908.
REQ-024 Write idx 3 tag 0x5 offset 8 wdata 0xDEADBEEF byte_en 0b0011 -> ready=0 one cycle; next read -> rdata=0x0B0ABEEF, dirty=1 on invalidate report.
REQ-025 Fills idx 3 tags 0x5,0x6,0x7 -> ways 0,1 by invalid scan, third to pointer way 0 with o_rsp_tag=0x5, dirty as set; fourth fill tag 0x8 -> way 1.
REQ-026 Back-to-back reads 10 cycles -> ready held 1, 10 responses in order; assert n_rst in a write's response cycle -> no data change, all lines invalid.
